// File: rtl/lsu_dmem_adapter_if.sv
// Bundle of the load/store request, response and data-memory signals of
// lsu_dmem_adapter.
//   slave  : the adapter side (takes requests, drives responses and memory)
//   master : the environment side (execute stage plus data memory)
// Request : req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata
// Response: resp_valid/resp_ready handshake, resp_rdata, resp_err
// Memory  : mem_rd_addr/mem_rd_data (async read), mem_wr_addr/mem_wr_data/mem_wr_en
interface lsu_dmem_adapter_if #(
    parameter int unsigned MEM_WIDTH = 12
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [MEM_WIDTH-1:0] mem_rd_addr;
    logic [63:0]          mem_rd_data;
    logic [MEM_WIDTH-1:0] mem_wr_addr;
    logic [63:0]          mem_wr_data;
    logic                 mem_wr_en;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en
    );
endinterface

// File: rtl/lsu_dmem_adapter.sv
// Load/store adapter between the RV32I execute stage and a 64-bit data memory
// (async read, sync write, no byte enables). One request at a time: the
// containing line is read, loads are extracted and sign/zero-extended, stores
// are merged into the line and written back. Misaligned or illegal requests
// return resp_err without touching memory.
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset
//   bus (slave)  : request/response handshakes and data-memory port
module lsu_dmem_adapter #(
    parameter int unsigned MEM_SIZE  = 4096,
    parameter int unsigned MEM_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic               clk,
    input  logic               aresetn,
    lsu_dmem_adapter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic                 we_q;
    logic [2:0]           f3_q;
    logic [2:0]           off_q;
    logic [MEM_WIDTH-1:0] idx_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 ready_q;
    logic                 valid_q;

    logic                 cap_en;
    logic                 f3_ok;
    logic                 align_ok;
    logic                 illegal;
    logic                 wr_en;
    logic [63:0]          wr_data;

    logic [5:0]           bit_sh;
    logic [63:0]          rd_shifted;
    logic [31:0]          load_val;
    logic                 sign_bit;
    logic [63:0]          lane_mask;
    logic [63:0]          mask_sh;
    logic [63:0]          data_sh;
    logic [63:0]          merged;

    // Legality of the incoming request (funct3 set, store size, alignment)
    always_comb begin
        f3_ok = 1'b0;
        unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~bus.req_we;
            default:                f3_ok = 1'b0;
        endcase
        align_ok = 1'b1;
        unique case (bus.req_funct3[1:0])
            2'b01:   align_ok = ~bus.req_addr[0];
            2'b10:   align_ok = (bus.req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        illegal = ~(f3_ok & align_ok);
    end

    // Lane select and merge on the captured line; offsets are size-aligned,
    // so an access never crosses the 64-bit line.
    assign bit_sh     = {off_q, 3'b000};
    assign rd_shifted = bus.mem_rd_data >> bit_sh;

    always_comb begin
        load_val = rd_shifted[31:0];
        sign_bit = 1'b0;
        unique case (f3_q[1:0])
            2'b00: begin
                sign_bit = ~f3_q[2] & rd_shifted[7];
                load_val = {{24{sign_bit}}, rd_shifted[7:0]};
            end
            2'b01: begin
                sign_bit = ~f3_q[2] & rd_shifted[15];
                load_val = {{16{sign_bit}}, rd_shifted[15:0]};
            end
            default: load_val = rd_shifted[31:0];
        endcase
    end

    always_comb begin
        unique case (f3_q[1:0])
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            default: lane_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
    end

    assign mask_sh = lane_mask << bit_sh;
    assign data_sh = {32'h0, wdata_q} << bit_sh;
    assign merged  = (bus.mem_rd_data & ~mask_sh) | (data_sh & mask_sh);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_data = 64'h0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cap_en  = 1'b1;
                    rdata_d = 32'h0;
                    err_d   = illegal;
                    state_d = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                err_d   = 1'b0;
                if (we_q) begin
                    wr_en   = 1'b1;
                    wr_data = merged;
                    rdata_d = 32'h0;
                end else begin
                    rdata_d = load_val;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 3'b000;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == RESP);
            if (cap_en) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                off_q   <= bus.req_addr[2:0];
                idx_q   <= bus.req_addr[MEM_WIDTH+2:3];
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Write strobe follows the state, so an async reset in ACCESS cancels it
    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = valid_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_rd_addr = idx_q;
    assign bus.mem_wr_addr = idx_q;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_wr_data = wr_data;

endmodule

// File: tb/tb_lsu_dmem_adapter.sv
// Scoreboard bench for lsu_dmem_adapter: a byte-addressed reference memory
// predicts every response; a monitor pops and compares responses as the DUT
// presents them, with randomised response back-pressure.
module tb_lsu_dmem_adapter;

    localparam int unsigned MEM_SIZE  = 4096;
    localparam int unsigned MEM_WIDTH = 12;
    localparam int unsigned N_LINES   = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic clk;
    logic aresetn;

    lsu_dmem_adapter_if #(.MEM_WIDTH(MEM_WIDTH)) bus ();

    lsu_dmem_adapter #(.MEM_SIZE(MEM_SIZE), .MEM_WIDTH(MEM_WIDTH)) u_dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [7:0]  ref_bytes [MEM_SIZE*8];
    logic [63:0] dmem [MEM_SIZE];
    int          wr_count  = 0;
    int          exp_wr    = 0;
    bit          force_hold = 1'b0;

    logic                 pl_en;
    logic [MEM_WIDTH-1:0] pl_idx;
    logic [63:0]          pl_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Data memory seen by the DUT: async read, write at posedge
    assign bus.mem_rd_data = dmem[bus.mem_rd_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            dmem[pl_idx] <= pl_data;
        end else if (bus.mem_wr_en) begin
            dmem[bus.mem_wr_addr] <= bus.mem_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    // Reference model: byte-addressed memory, RV32I load/store rules
    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int size;
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
        if (we && f3[2]) return 1'b0;
        size = 1 << f3[1:0];
        return (addr % size) == 0;
    endfunction

    function automatic int ref_base(input logic [31:0] addr);
        return int'(((addr >> 3) % MEM_SIZE) * 8 + (addr % 8));
    endfunction

    task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rdata, output logic err);
        int size;
        int base;
        logic [31:0] v;
        rdata = 32'h0;
        err   = 1'b0;
        if (!ref_legal(we, f3, addr)) begin
            err = 1'b1;
            return;
        end
        size = 1 << f3[1:0];
        base = ref_base(addr);
        if (we) begin
            for (int i = 0; i < size; i++) ref_bytes[base+i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[base+i];
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            rdata = v;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input string name, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        ref_access(we, f3, addr, wd, e.rdata, e.err);
        e.name = name;
        exp_q.push_back(e);
        if (we && !e.err) exp_wr++;
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.resp_valid && bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   64'(bus.req_ready),   64'd1);
        chk({tag, "_resp_valid"},  64'(bus.resp_valid),  64'd0);
        chk({tag, "_resp_rdata"},  64'(bus.resp_rdata),  64'd0);
        chk({tag, "_resp_err"},    64'(bus.resp_err),    64'd0);
        chk({tag, "_mem_wr_en"},   64'(bus.mem_wr_en),   64'd0);
        chk({tag, "_mem_wr_addr"}, 64'(bus.mem_wr_addr), 64'd0);
        chk({tag, "_mem_rd_addr"}, 64'(bus.mem_rd_addr), 64'd0);
        chk({tag, "_mem_wr_data"}, bus.mem_wr_data,      64'd0);
    endtask

    // Response monitor: pops on first presentation, then checks stability
    bit          seen;
    bit          prev_hs;
    int          hold;
    logic [31:0] held_rdata;
    logic        held_err;

    always @(negedge clk) begin
        exp_t e;
        if (!aresetn) begin
            seen            = 1'b0;
            prev_hs         = 1'b0;
            hold            = 0;
            bus.resp_ready  = 1'b0;
        end else begin
            if (prev_hs) begin
                chk("req_ready_after_release", 64'(bus.req_ready), 64'd1);
                prev_hs = 1'b0;
            end
            if (bus.resp_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_response", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_rdata"}, 64'(bus.resp_rdata), 64'(e.rdata));
                        chk({e.name, "_err"},   64'(bus.resp_err),   64'(e.err));
                    end
                    held_rdata = bus.resp_rdata;
                    held_err   = bus.resp_err;
                    seen       = 1'b1;
                    hold       = force_hold ? 5 : int'($urandom_range(0, 2));
                end else begin
                    chk("resp_rdata_stable", 64'(bus.resp_rdata), 64'(held_rdata));
                    chk("resp_err_stable",   64'(bus.resp_err),   64'(held_err));
                end
                chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
                chk("wr_en_in_resp",     64'(bus.mem_wr_en), 64'd0);
                bus.resp_ready = (hold == 0);
                if (hold > 0) hold--;
                prev_hs = bus.resp_ready;
            end else begin
                seen           = 1'b0;
                bus.resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        logic [63:0] line;
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          we;
        bit          ok;
        int          sel;
        logic [2:0]  legal_f3 [5];

        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        aresetn        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        pl_en          = 1'b0;
        pl_idx         = '0;
        pl_data        = 64'h0;

        // Preload lines 0..7 into both the DUT memory and the reference
        for (int i = 0; i < int'(N_LINES); i++) begin
            line = (i == 5) ? 64'h8877_6655_4433_2211 : {$urandom, $urandom};
            for (int b = 0; b < 8; b++) ref_bytes[i*8+b] = line[8*b +: 8];
            @(negedge clk);
            pl_en   = 1'b1;
            pl_idx  = MEM_WIDTH'(i);
            pl_data = line;
        end
        @(negedge clk);
        pl_en = 1'b0;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 aresetn = 1'b1;

        // Directed cases on line 5
        issue("lb_2f",  1'b0, 3'd0, 32'h2F, 32'h0);
        issue("lbu_2f", 1'b0, 3'd4, 32'h2F, 32'h0);
        issue("lw_28",  1'b0, 3'd2, 32'h28, 32'h0);
        issue("sb_2a",  1'b1, 3'd0, 32'h2A, 32'h1234_56AB);
        issue("lw_28b", 1'b0, 3'd2, 32'h28, 32'h0);
        issue("lw_2c",  1'b0, 3'd2, 32'h2C, 32'h0);
        issue("sh_2e",  1'b1, 3'd1, 32'h2E, 32'h5555_BEEF);
        issue("lh_2e",  1'b0, 3'd1, 32'h2E, 32'h0);
        issue("lhu_2e", 1'b0, 3'd5, 32'h2E, 32'h0);
        issue("lw_2a",  1'b0, 3'd2, 32'h2A, 32'h0);
        issue("sh_29",  1'b1, 3'd1, 32'h29, 32'hFFFF_FFFF);
        issue("sbu_28", 1'b1, 3'd4, 32'h28, 32'h0000_00CC);
        issue("f3_3",   1'b0, 3'd3, 32'h28, 32'h0);
        issue("wrap_sw", 1'b1, 3'd2, 32'hABCD_0000 | (32'(MEM_SIZE) << 3) | 32'h30, 32'hCAFE_F00D);
        issue("wrap_lw", 1'b0, 3'd2, 32'h30, 32'h0);
        wait_idle();

        // Back-pressure: response held for 5 cycles
        force_hold = 1'b1;
        issue("lw_bp", 1'b0, 3'd2, 32'h28, 32'h0);
        wait_idle();
        force_hold = 1'b0;

        // Reset during the ACCESS cycle of a store cancels the write
        wait_ready(ok);
        if (ok) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'd2;
            bus.req_addr   = 32'h28;
            bus.req_wdata  = 32'hDEAD_BEEF;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            chk("access_wr_en", 64'(bus.mem_wr_en), 64'd1);
            #1 aresetn = 1'b0;
            #1 check_reset_outputs("mid_reset");
            @(posedge clk);
            @(posedge clk);
            #1 check_reset_outputs("held_reset");
            #1 aresetn = 1'b1;
        end
        issue("lw_after_rst", 1'b0, 3'd2, 32'h28, 32'h0);
        wait_idle();

        // Randomised traffic over a few lines with random wrap bits
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            f3  = (sel < 5) ? legal_f3[sel] : 3'($urandom_range(0, 7));
            we  = ($urandom_range(0, 2) == 0);
            addr = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, N_LINES-1)) << 3)
                   | 32'($urandom_range(0, 7));
            issue("rand", we, f3, addr, $urandom);
        end
        wait_idle();

        chk("write_count", 64'(wr_count), 64'(exp_wr));
        for (int i = 0; i < int'(N_LINES); i++) begin
            for (int b = 0; b < 8; b++) line[8*b +: 8] = ref_bytes[i*8+b];
            chk("final_line", dmem[i], line);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
